// File: rtl/wb_stage.sv
// Write-back stage: commits one packet per cycle to the register file and CSRs,
// raises exceptions/ERTN, and squashes the following cycle after any flush.
module wb_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic         MEM_to_WB,
  input  logic [102:0] MEM_to_WB_reg,
  input  logic [118:0] MEM_except_reg,
  output logic         WB_allowin,
  output logic         rf_we,
  output logic [4:0]   rf_waddr,
  output logic [31:0]  rf_wdata,
  output logic         front_valid,
  output logic [4:0]   front_addr,
  output logic [31:0]  front_data,
  output logic         csr_we,
  output logic [13:0]  csr_num,
  output logic [31:0]  csr_wmask,
  output logic [31:0]  csr_wvalue,
  output logic         wb_ex,
  output logic [5:0]   wb_ecode,
  output logic [8:0]   wb_esubcode,
  output logic [31:0]  wb_pc,
  output logic [31:0]  wb_vaddr,
  output logic         ertn_flush,
  output logic         flush,
  output logic [31:0]  debug_wb_pc,
  output logic [3:0]   debug_wb_rf_we,
  output logic [4:0]   debug_wb_rf_wnum,
  output logic [31:0]  debug_wb_rf_wdata
);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] SQUASH = 1'b1;

  logic [0:0]  state;
  logic        wb_valid;
  logic [31:0] pc_p0;
  logic        gr_we_p0;
  logic [4:0]  waddr_p0;
  logic [31:0] wdata_p0;
  logic [31:0] csr_wvalue_p0;
  logic [31:0] csr_wmask_p0;
  logic [13:0] csr_num_p0;
  logic        csr_we_p0;
  logic        intr_p0, ertn_p0, brk_p0, sys_p0, ine_p0, adef_p0, ale_p0;
  logic [31:0] bad_addr_p0;
  logic        accept;
  logic        exc;
  logic        unused_fields;

  // IR and csr_re are carried by the packet but not needed at commit.
  assign unused_fields = ^{MEM_to_WB_reg[69:38], MEM_except_reg[40]};

  // A packet arriving in the commit cycle of a flushing instruction is dropped.
  assign accept = MEM_to_WB & (state == RUN) & ~flush;

  // ---- stage p0: accepted packet ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      wb_valid      <= 1'b0;
      pc_p0         <= '0;
      gr_we_p0      <= 1'b0;
      waddr_p0      <= '0;
      wdata_p0      <= '0;
      csr_wvalue_p0 <= '0;
      csr_wmask_p0  <= '0;
      csr_num_p0    <= '0;
      csr_we_p0     <= 1'b0;
      intr_p0       <= 1'b0;
      ertn_p0       <= 1'b0;
      brk_p0        <= 1'b0;
      sys_p0        <= 1'b0;
      ine_p0        <= 1'b0;
      adef_p0       <= 1'b0;
      ale_p0        <= 1'b0;
      bad_addr_p0   <= '0;
    end else begin
      case (state)
        RUN:     state <= flush ? SQUASH : RUN;
        default: state <= RUN;
      endcase
      wb_valid <= accept & MEM_to_WB_reg[102];
      if (accept) begin
        pc_p0         <= MEM_to_WB_reg[101:70];
        gr_we_p0      <= MEM_to_WB_reg[37];
        waddr_p0      <= MEM_to_WB_reg[36:32];
        wdata_p0      <= MEM_to_WB_reg[31:0];
        csr_wvalue_p0 <= MEM_except_reg[118:87];
        csr_wmask_p0  <= MEM_except_reg[86:55];
        csr_num_p0    <= MEM_except_reg[54:41];
        csr_we_p0     <= MEM_except_reg[39];
        intr_p0       <= MEM_except_reg[38];
        ertn_p0       <= MEM_except_reg[37];
        brk_p0        <= MEM_except_reg[36];
        sys_p0        <= MEM_except_reg[35];
        ine_p0        <= MEM_except_reg[34];
        adef_p0       <= MEM_except_reg[33];
        ale_p0        <= MEM_except_reg[32];
        bad_addr_p0   <= MEM_except_reg[31:0];
      end
    end
  end

  assign exc = wb_valid & (intr_p0 | adef_p0 | ine_p0 | sys_p0 | brk_p0 | ale_p0);

  // Priority chain: the winning cause also selects the BADV source.
  always_comb begin
    wb_ecode = 6'h00;
    wb_vaddr = 32'h0;
    if (exc) begin
      if (intr_p0) begin
        wb_ecode = 6'h00;
      end else if (adef_p0) begin
        wb_ecode = 6'h08;
        wb_vaddr = pc_p0;
      end else if (ine_p0) begin
        wb_ecode = 6'h0D;
      end else if (sys_p0) begin
        wb_ecode = 6'h0B;
      end else if (brk_p0) begin
        wb_ecode = 6'h0C;
      end else begin
        wb_ecode = 6'h09;
        wb_vaddr = bad_addr_p0;
      end
    end
  end

  assign WB_allowin  = (state == RUN);
  assign wb_ex       = exc;
  assign wb_esubcode = 9'h000;
  assign wb_pc       = pc_p0;
  assign ertn_flush  = wb_valid & ertn_p0 & ~exc;
  assign flush       = wb_ex | ertn_flush;

  assign rf_we    = wb_valid & gr_we_p0 & ~exc & (waddr_p0 != 5'd0);
  assign rf_waddr = waddr_p0;
  assign rf_wdata = wdata_p0;

  assign csr_we     = wb_valid & csr_we_p0 & ~exc;
  assign csr_num    = csr_num_p0;
  assign csr_wmask  = csr_wmask_p0;
  assign csr_wvalue = csr_wvalue_p0;

  assign front_valid = rf_we;
  assign front_addr  = waddr_p0;
  assign front_data  = wdata_p0;

  assign debug_wb_pc       = pc_p0;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = waddr_p0;
  assign debug_wb_rf_wdata = wdata_p0;

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The block SHALL expose the following ports (clock and reset first):
  clk  in  1  single clock; all state updates on its rising edge.
  rst  in  1  reset, synchronous, active-high.
  MEM_to_WB  in  1  transfer strobe from the memory stage; a packet is accepted on this cycle.
  MEM_to_WB_reg  in  103  {valid[102], pc[101:70], IR[69:38], gr_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
  MEM_except_reg  in  119  {csr_wvalue[118:87], csr_wmask[86:55], csr_num[54:41], csr_re[40], csr_we[39], int[38], ertn[37], brk[36], sys[35], ine[34], adef[33], ale[32], bad_addr[31:0]}.
  WB_allowin  out  1  stage can accept a packet next edge.
  rf_we / rf_waddr / rf_wdata  out  1/5/32  register-file write port.
  front_valid / front_addr / front_data  out  1/5/32  forwarding to decode.
  csr_we / csr_num / csr_wmask / csr_wvalue  out  1/14/32/32  CSR write port.
  wb_ex  out  1  exception commit.
  wb_ecode / wb_esubcode  out  6/9  exception code.
  wb_pc / wb_vaddr  out  32/32  ERA and BADV sources.
  ertn_flush  out  1  ERTN commit.
  flush  out  1  pipeline flush to all upstream stages.
  debug_wb_pc / debug_wb_rf_we / debug_wb_rf_wnum / debug_wb_rf_wdata  out  32/4/5/32  retire trace.

Function
REQ-002 The block SHALL hold the accepted packet in internal registers (wb_valid, fields) loaded on every MEM_to_WB edge; wb_valid SHALL take MEM_to_WB_reg[102].
REQ-003 Without MEM_to_WB, wb_valid SHALL clear after one cycle; each packet commits in exactly one cycle.
REQ-004 A state machine SHALL have states RUN and SQUASH; RUN->SQUASH on any cycle flush=1; SQUASH->RUN unconditionally next cycle.
REQ-005 WB_allowin SHALL be 1 in RUN and 0 in SQUASH; a MEM_to_WB in SQUASH SHALL be discarded (wb_valid stays 0).
REQ-006 exc SHALL equal wb_valid & (int|adef|ine|sys|brk|ale); wb_ex = exc.
REQ-007 Priority, highest first, with ecode: int 0x00, adef 0x08, ine 0x0D, sys 0x0B, brk 0x0C, ale 0x09; wb_esubcode SHALL be 0 for all.
REQ-008 wb_vaddr SHALL be pc for adef and bad_addr for ale, else 0; wb_pc SHALL be the packet pc.
REQ-009 ertn_flush SHALL equal wb_valid & ertn & ~exc.
REQ-010 flush SHALL equal wb_ex | ertn_flush, combinationally in the commit cycle.
REQ-011 rf_we SHALL equal wb_valid & gr_we & ~exc & (rf_waddr!=0); rf_waddr/rf_wdata pass through.
REQ-012 csr_we SHALL equal wb_valid & csr_we-field & ~exc; csr_num/wmask/wvalue pass through.
REQ-013 front_valid SHALL equal rf_we; front_addr=rf_waddr; front_data=rf_wdata.
REQ-014 debug_wb_pc=pc; debug_wb_rf_we={4{rf_we}}; debug_wb_rf_wnum=rf_waddr; debug_wb_rf_wdata=rf_wdata.
REQ-015 Simultaneous flush and MEM_to_WB SHALL load nothing new; the SQUASH cycle follows.
REQ-016 All outputs SHALL be functions of registered state only (no input-to-output combinational path) except WB_allowin, which depends on state only.

Reset
REQ-017 On rst: state=RUN, wb_valid=0, all packet registers 0; hence rf_we, csr_we, wb_ex, ertn_flush, flush, debug_wb_rf_we all 0, WB_allowin=1.
REQ-018 rst mid-SQUASH or mid-commit SHALL abort: no write or flush emitted in the cycle after the rst edge.

Verification
REQ-019 ALU retire: packet valid=1, pc=0x1C000000, gr_we=1, rf_waddr=5, rf_wdata=0x1234 -> next cycle rf_we=1, waddr=5, data=0x1234, debug_wb_rf_we=0xF, flush=0.
REQ-020 Load ALE: valid=1, gr_we=1, ale=1, bad_addr=0x1C000003 -> wb_ex=1, ecode=0x09, wb_vaddr=0x1C000003, rf_we=0, flush=1, WB_allowin=0 next cycle.
REQ-021 Priority: int=1, sys=1, ale=1 same packet -> ecode=0x00, csr_we=0.
REQ-022 ERTN: ertn=1 -> ertn_flush=1, wb_ex=0, flush=1; MEM_to_WB asserted in following cycle -> discarded, no rf_we two cycles later.
REQ-023 Write to r0: gr_we=1, rf_waddr=0 -> rf_we=0, front_valid=0.
REQ-024 rst asserted during SQUASH -> next cycle state RUN, WB_allowin=1, all write/flush outputs 0.
